// File: rtl/sim_pkg.sv
// Shared definitions for the simulation fabric: scheduler states, return
// codes and the process-index width helper.
package sim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PRINT = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

    localparam logic RC_STOPPED = 1'b0;
    localparam logic RC_TIMEOUT = 1'b1;

    // A single process still needs a one-bit index.
    function automatic int PROCESS_INDEX_W(input int n);
        int w;
        w = (n > 1) ? $clog2(n) : 1;
        return w;
    endfunction

endpackage

// File: rtl/process_scheduler.sv
// Step sequencer: one init step, then one grant per process per step in index
// order, a print strobe after each step, halting on stop or budget exhaustion.
module process_scheduler
    import sim_pkg::*;
#(
    parameter int PROCESSES  = 4,
    parameter int STEP_WIDTH = 32,
    localparam int IDX_W     = PROCESS_INDEX_W(PROCESSES)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [STEP_WIDTH-1:0] max_steps,
    input  logic [PROCESSES-1:0]         proc_stop,
    output logic                         proc_init,
    output logic [PROCESSES-1:0]         proc_grant,
    output logic [IDX_W-1:0]             process_current,
    output logic signed [STEP_WIDTH-1:0] step,
    output logic                         print_strobe,
    output logic                         running,
    output logic                         done,
    output logic                         return_code
);

    localparam logic signed [STEP_WIDTH-1:0] STEP_ZERO = '0;
    localparam logic signed [STEP_WIDTH-1:0] STEP_NEG1 = '1;
    localparam logic signed [STEP_WIDTH-1:0] STEP_ONE  = STEP_WIDTH'(1'b1);
    localparam logic signed [STEP_WIDTH-1:0] STEP_MAX  = {1'b0, {(STEP_WIDTH-1){1'b1}}};
    localparam logic [IDX_W-1:0]             IDX_ONE   = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0]             IDX_LAST  = IDX_W'(PROCESSES - 1);
    localparam logic [PROCESSES-1:0]         GRANT_ONE = PROCESSES'(1'b1);
    localparam logic [PROCESSES-1:0]         GRANT_ALL = '1;

    sched_state_t                   state_q, state_d;
    logic signed [STEP_WIDTH-1:0]   max_q, max_d;
    logic signed [STEP_WIDTH-1:0]   step_q, step_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [PROCESSES-1:0]           grant_q, grant_d;
    logic                           init_q, init_d;
    logic                           print_q, print_d;
    logic                           running_q, running_d;
    logic                           done_q, done_d;
    logic                           rc_q, rc_d;
    logic signed [STEP_WIDTH-1:0]   step_inc_s;

    assign step_inc_s = (step_q == STEP_MAX) ? step_q : (step_q + STEP_ONE);

    // Next-state and next-output logic; outputs describe the state being entered.
    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        step_d    = step_q;
        idx_d     = '0;
        grant_d   = '0;
        init_d    = 1'b0;
        print_d   = 1'b0;
        running_d = 1'b0;
        done_d    = 1'b0;
        rc_d      = rc_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_INIT;
                    max_d     = max_steps;
                    step_d    = STEP_NEG1;
                    init_d    = 1'b1;
                    grant_d   = GRANT_ALL;
                    running_d = 1'b1;
                end else begin
                    done_d = (state_q == ST_DONE);
                end
            end
            ST_INIT: begin
                if (max_q <= STEP_ZERO) begin
                    state_d = ST_DONE;
                    rc_d    = RC_TIMEOUT;
                    done_d  = 1'b1;
                end else begin
                    state_d   = ST_RUN;
                    step_d    = STEP_ZERO;
                    grant_d   = GRANT_ONE;
                    running_d = 1'b1;
                end
            end
            ST_RUN: begin
                running_d = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_PRINT;
                    print_d = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    grant_d = GRANT_ONE << (idx_q + IDX_ONE);
                end
            end
            ST_PRINT: begin
                // Stop takes priority over budget exhaustion.
                if (|proc_stop) begin
                    state_d = ST_DONE;
                    rc_d    = RC_STOPPED;
                    done_d  = 1'b1;
                end else if (step_inc_s >= max_q) begin
                    state_d = ST_DONE;
                    rc_d    = RC_TIMEOUT;
                    done_d  = 1'b1;
                end else begin
                    state_d   = ST_RUN;
                    step_d    = step_inc_s;
                    grant_d   = GRANT_ONE;
                    running_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            max_q     <= '0;
            step_q    <= '0;
            idx_q     <= '0;
            grant_q   <= '0;
            init_q    <= 1'b0;
            print_q   <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            rc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            step_q    <= step_d;
            idx_q     <= idx_d;
            grant_q   <= grant_d;
            init_q    <= init_d;
            print_q   <= print_d;
            running_q <= running_d;
            done_q    <= done_d;
            rc_q      <= rc_d;
        end
    end

    assign proc_init       = init_q;
    assign proc_grant      = grant_q;
    assign process_current = idx_q;
    assign step            = step_q;
    assign print_strobe    = print_q;
    assign running         = running_q;
    assign done            = done_q;
    assign return_code     = rc_q;

endmodule

// File: tb/tb_process_scheduler.sv
// Scoreboard bench for process_scheduler: each run's expected event timeline
// is queued up front from cycle arithmetic and checked by a separate monitor.
module tb_process_scheduler;

    localparam int P  = 2;
    localparam int SW = 8;
    localparam int IW = 1;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start;
    logic signed [SW-1:0] max_steps;
    logic [P-1:0]         proc_stop;
    logic                 proc_init;
    logic [P-1:0]         proc_grant;
    logic [IW-1:0]        process_current;
    logic signed [SW-1:0] step;
    logic                 print_strobe;
    logic                 running;
    logic                 done;
    logic                 return_code;

    process_scheduler #(.PROCESSES(P), .STEP_WIDTH(SW)) dut (
        .clock(clock), .reset(reset), .start(start), .max_steps(max_steps),
        .proc_stop(proc_stop), .proc_init(proc_init), .proc_grant(proc_grant),
        .process_current(process_current), .step(step), .print_strobe(print_strobe),
        .running(running), .done(done), .return_code(return_code)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        int                   cyc;
        logic                 init;
        logic [P-1:0]         grant;
        logic [IW-1:0]        pc;
        logic signed [SW-1:0] step;
        logic                 print;
        logic                 run;
        logic                 done;
        logic                 rc;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    function automatic string fmt(ev_t e);
        return $sformatf("cyc=%0d init=%0b grant=%b pc=%0d step=%0d print=%0b run=%0b done=%0b rc=%0b",
                         e.cyc, e.init, e.grant, e.pc, $signed(e.step), e.print, e.run, e.done, e.rc);
    endfunction

    function automatic ev_t mk(int c, bit i, int g, int pc, int s, bit pr, bit rn, bit dn, bit rc);
        ev_t e;
        e.cyc   = c;
        e.init  = i;
        e.grant = g[P-1:0];
        e.pc    = pc[IW-1:0];
        e.step  = s[SW-1:0];
        e.print = pr;
        e.run   = rn;
        e.done  = dn;
        e.rc    = rc;
        return e;
    endfunction

    // Monitor: compare every visible DUT event against the queued expectation.
    bit done_prev = 1'b0;
    always @(negedge clock) begin
        ev_t obs;
        ev_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_event actual=none required %s", fmt(exp_q[0]));
            void'(exp_q.pop_front());
        end
        if (proc_init || (proc_grant != '0) || print_strobe || (done && !done_prev)) begin
            obs.cyc   = cyc;
            obs.init  = proc_init;
            obs.grant = proc_grant;
            obs.pc    = process_current;
            obs.step  = step;
            obs.print = print_strobe;
            obs.run   = running;
            obs.done  = done;
            obs.rc    = done ? return_code : 1'b0;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual %s required none", fmt(obs));
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    failures++;
                    $display("FAIL event actual %s required %s", fmt(obs), fmt(e));
                end
            end
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({proc_init, proc_grant, process_current, step, print_strobe, running, done, return_code} !== '0) begin
            failures++;
            $display("FAIL %s actual init=%0b grant=%b pc=%0d step=%0d print=%0b run=%0b done=%0b rc=%0b required all zero",
                     name, proc_init, proc_grant, process_current, step, print_strobe, running, done, return_code);
        end
    endtask

    // One run: mx budget, stop raised in PRINT of step k (-1 none), gap idle
    // cycles before start, rst_mode -1 none / -2 random / >=0 offset from INIT.
    task automatic run(input int mx, input int k, input int gap, input int rst_mode);
        int  t0, n, steps, fin, d, r, off, s;
        bit  stopped, rc;
        ev_t e;
        for (int i = 0; i < gap; i++) begin
            start     = 1'b0;
            proc_stop = P'($urandom);
            max_steps = SW'($urandom);
            tick();
        end
        start     = 1'b1;
        max_steps = SW'(mx);
        proc_stop = P'($urandom);
        t0        = cyc + 1;
        n         = (mx <= 0) ? 0 : mx;
        stopped   = (k >= 0) && (k < n);
        steps     = stopped ? k + 1 : n;
        fin       = steps - 1;
        rc        = stopped ? 1'b0 : 1'b1;
        d         = t0 + 1 + steps * (P + 1);
        if (rst_mode == -2) r = t0 + $urandom_range(0, d - t0 - 1);
        else if (rst_mode >= 0) r = t0 + rst_mode;
        else r = d + 1;
        exp_q.push_back(mk(t0, 1'b1, (1 << P) - 1, 0, -1, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int si = 0; si < steps; si++) begin
            for (int pi = 0; pi < P; pi++) begin
                e = mk(t0 + 1 + si * (P + 1) + pi, 1'b0, 1 << pi, pi, si, 1'b0, 1'b1, 1'b0, 1'b0);
                if (e.cyc <= r) exp_q.push_back(e);
            end
            e = mk(t0 + 1 + si * (P + 1) + P, 1'b0, 0, 0, si, 1'b1, 1'b1, 1'b0, 1'b0);
            if (e.cyc <= r) exp_q.push_back(e);
        end
        if (d <= r) exp_q.push_back(mk(d, 1'b0, 0, 0, fin, 1'b0, 1'b0, 1'b1, rc));
        for (int guard = 0; guard < 2000; guard++) begin
            tick();
            if (cyc == r) begin
                reset = 1'b1;
                start = 1'b0;
                tick();
                reset = 1'b0;
                @(negedge clock);
                check_reset_values("reset_midrun");
                return;
            end
            if (cyc == d) begin
                start = 1'b0;
                return;
            end
            start     = ($urandom_range(0, 3) == 0);
            max_steps = SW'($urandom);
            off       = cyc - (t0 + 1);
            if (off >= 0 && (off % (P + 1)) == P) begin
                s         = off / (P + 1);
                proc_stop = (s == k) ? P'($urandom_range(1, (1 << P) - 1)) : '0;
            end else begin
                proc_stop = P'($urandom);
            end
        end
        checks++;
        failures++;
        $display("FAIL run_timeout actual cyc=%0d required done_cyc=%0d", cyc, d);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        max_steps = '0;
        proc_stop = '0;
        repeat (3) tick();
        @(negedge clock);
        check_reset_values("reset_state");
        reset = 1'b0;

        run(3, -1, 1, -1);
        run(100, 1, 2, -1);
        run(0, -1, 0, -1);
        run(1, 0, 1, -1);
        run(10, -1, 1, 1 + 2 * (P + 1) + 1);
        run(5, -1, 2, -1);
        run(2, -1, 0, -1);
        run(-3, -1, 1, -1);
        run(127, -1, 1, -1);
        for (int it = 0; it < 25; it++) begin
            run(int'($urandom_range(0, 10)) - 2,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1,
                $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0) ? -2 : -1);
        end

        repeat (3) tick();
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_events actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/process_scheduler.md
# process_scheduler

Single-threaded step sequencer for the database-on-a-chip simulation fabric. It sits directly upstream of the generated process blocks: it runs one unconditional initialisation step, then grants each process exactly one clock per step in fixed index order. After every step it pulses a print strobe for the trace writer. It halts when any process raises stop or when the step budget is exhausted. This gives Java and Verilog runs identical instruction interleaving.

## Interface
- PROCESSES, 4, number of process blocks scheduled (1..16)
- STEP_WIDTH, 32, width of the signed step counter and of the max_steps input
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high; returns the block to IDLE
- start  in  1  single-cycle pulse; begins a run from IDLE or DONE
- max_steps  in  STEP_WIDTH  step budget; sampled on the accepted start cycle only
- proc_stop  in  PROCESSES  per-process stop flags; the block uses their OR
- proc_init  out  1  high during the initialisation step; processes clear their pc, registers and stop
- proc_grant  out  PROCESSES  one-hot grant during RUN; all ones during INIT; zero otherwise
- process_current  out  $clog2(PROCESSES) (min 1)  index of the granted process; 0 outside RUN
- step  out  STEP_WIDTH signed  current step number; -1 during INIT
- print_strobe  out  1  one-cycle pulse after each completed step >= 0
- running  out  1  high in INIT, RUN and PRINT
- done  out  1  high in DONE
- return_code  out  1  valid when done: 0 = halted by stop, 1 = budget exhausted

## Operation
- States: IDLE, INIT, RUN, PRINT, DONE.
- IDLE:
  - start -> INIT; latch max_steps; step <= -1.
- INIT (1 cycle):
  - proc_init=1, proc_grant=all ones.
  - Next state: if latched max_steps <= 0 -> DONE, return_code=1, no print. Otherwise -> RUN with step <= 0 and process_current <= 0.
- RUN (PROCESSES cycles):
  - proc_grant = 1 << process_current.
  - process_current increments each cycle.
  - After index PROCESSES-1 -> PRINT.
- PRINT (1 cycle):
  - print_strobe=1; step holds the number of the step just completed.
  - Stop sample is |proc_stop in this cycle. If high -> DONE, return_code=0.
  - Else if step+1 >= max_steps -> DONE, return_code=1.
  - Else -> RUN with step <= step+1 and process_current <= 0.
  - If stop and budget exhaustion coincide, stop wins (return_code=0).
- DONE:
  - Holds step and return_code.
  - start -> INIT (restart; step re-initialised to -1, new max_steps latched).
- start is ignored in INIT, RUN and PRINT.
- proc_stop is ignored outside PRINT. A process stopping mid-step still lets the remaining processes take their turn in that step.
- Step arithmetic is signed, two's complement. Increment saturates at the maximum positive value; it does not wrap.

## Timing
- Reset values:
  - state=IDLE
  - step=0, process_current=0, proc_grant=0
  - proc_init=0, print_strobe=0
  - running=0, done=0, return_code=0
- Reset asserted mid-run takes effect on the next edge: all outputs go to reset values, and any step in progress is abandoned with no print.
- All outputs are registered (Moore).
- Latency from start to the first RUN grant is 2 cycles: start, INIT, RUN.
- One step takes PROCESSES+1 cycles.
- A run of N steps (no stop) takes 1 + N*(PROCESSES+1) cycles from INIT to DONE entry.
- Exactly one proc_grant bit is high in any RUN cycle; there are no gaps between grants within a step.

## Structure
- Shared package (`sim_pkg`) holds:
  - the state enum `sched_state_t`
  - return code constants `RC_STOPPED=0` and `RC_TIMEOUT=1`
  - `PROCESS_INDEX_W` helper function
- The package is reused by the generated process blocks and the trace writer.
- No sub-module; one FSM plus step and index counters.

## Test plan
- PROCESSES=2, max_steps=3, proc_stop=0:
  - Grants follow 11 (INIT), then 01, 10, print, repeated for steps 0, 1, 2.
  - done after 10 cycles; return_code=1; exactly 3 print strobes.
- PROCESSES=2, max_steps=100, proc_stop[1] raised during step 1 RUN:
  - print strobe at step=1, then DONE with step=1 and return_code=0.
- max_steps=0:
  - INIT for one cycle, then DONE; return_code=1; no grants, no print.
- stop and budget coincide (max_steps=1, stop raised in step 0):
  - return_code=0.
- reset asserted during RUN at step 2:
  - Next cycle all outputs are at reset values.
  - A later start sends proc_init high again with step=-1.
- start pulsed during RUN is ignored (sequence unchanged).
- start pulsed in DONE restarts with the newly latched max_steps=2: 2 prints, then done.
